// File: rtl/can_bit_destuffer.sv
// CAN receive bit destuffer: resolves sampled bits (single or 2-of-3 vote),
// integrates bus idle, strips stuff bits and flags stuff violations.
//
// Ports:
//   clk, resetN          clock, async active-low reset
//   sampleStrobe/Bit     sample pulse and bus level (1 = recessive)
//   multiSelect          0: 1 strobe/bit, 1: 3 strobes/bit majority
//   bitRestart           clears a partial vote
//   stuffEnable          destuffing active when 1
//   frameEnd             frame complete (acted on only in RX)
//   bitOut/bitValid      destuffed bit and its pulse
//   stuffDropped         stuff bit removed
//   stuffError           six equal bits seen
//   sofDetect            start of frame, with its bitValid
//   busIdle              level, bus integrated idle
module can_bit_destuffer (
  input  logic clk,
  input  logic resetN,
  input  logic sampleStrobe,
  input  logic sampleBit,
  input  logic multiSelect,
  input  logic bitRestart,
  input  logic stuffEnable,
  input  logic frameEnd,
  output logic bitOut,
  output logic bitValid,
  output logic stuffDropped,
  output logic stuffError,
  output logic sofDetect,
  output logic busIdle
);

  typedef enum logic [1:0] {
    INTEGRATE,
    IDLE,
    RX,
    ERROR
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] acc_q, acc_d;
  logic       mode_q, mode_d;
  logic [2:0] run_q, run_d;
  logic       rv_q, rv_d;
  logic [3:0] rec_q, rec_d;
  logic       fep_q, fep_d;

  logic out_q, out_d;
  logic val_q, val_d;
  logic drp_q, drp_d;
  logic err_q, err_d;
  logic sof_q, sof_d;

  logic mode;
  logic res;
  logic rbit;
  logic [1:0] vote;

  // Bit resolution. The vote mode is sampled only at the first strobe
  // of a bit, so a mid-bit change of multiSelect waits for the next bit.
  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    mode_d = mode_q;
    res    = 1'b0;
    rbit   = 1'b0;
    mode   = (cnt_q == 2'd0) ? multiSelect : mode_q;
    vote   = acc_q + {1'b0, sampleBit};
    if (bitRestart) begin
      cnt_d = 2'd0;
      acc_d = 2'd0;
    end else if (sampleStrobe) begin
      if (!mode) begin
        res  = 1'b1;
        rbit = sampleBit;
      end else if (cnt_q == 2'd2) begin
        res   = 1'b1;
        rbit  = vote[1];
        cnt_d = 2'd0;
        acc_d = 2'd0;
      end else begin
        cnt_d  = cnt_q + 2'd1;
        acc_d  = vote;
        mode_d = mode;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    rv_d    = rv_q;
    rec_d   = rec_q;
    fep_d   = 1'b0;
    out_d   = out_q;
    val_d   = 1'b0;
    drp_d   = 1'b0;
    err_d   = 1'b0;
    sof_d   = 1'b0;
    unique case (state_q)
      INTEGRATE: begin
        if (res) begin
          if (!rbit) begin
            rec_d = 4'd0;
          end else if (rec_q < 4'd11) begin
            rec_d = rec_q + 4'd1;
          end
          if (rbit && rec_q >= 4'd10) begin
            state_d = IDLE;
          end
        end
      end
      IDLE: begin
        if (res && !rbit) begin
          sof_d   = 1'b1;
          val_d   = 1'b1;
          out_d   = 1'b0;
          rv_d    = 1'b0;
          run_d   = 3'd1;
          state_d = RX;
        end
      end
      RX: begin
        if (res) begin
          // A frameEnd arriving with a bit is held until after it.
          fep_d = frameEnd | fep_q;
          if (!stuffEnable) begin
            val_d = 1'b1;
            out_d = rbit;
            run_d = 3'd0;
          end else if (run_q == 3'd0) begin
            val_d = 1'b1;
            out_d = rbit;
            rv_d  = rbit;
            run_d = 3'd1;
          end else if (run_q < 3'd5) begin
            val_d = 1'b1;
            out_d = rbit;
            if (rbit == rv_q) begin
              run_d = run_q + 3'd1;
            end else begin
              rv_d  = rbit;
              run_d = 3'd1;
            end
          end else if (rbit != rv_q) begin
            drp_d = 1'b1;
            rv_d  = rbit;
            run_d = 3'd1;
          end else begin
            err_d   = 1'b1;
            fep_d   = 1'b0;
            state_d = ERROR;
          end
        end else if (frameEnd || fep_q) begin
          state_d = IDLE;
        end
      end
      ERROR: begin
        rec_d   = 4'd0;
        state_d = INTEGRATE;
      end
      default: state_d = INTEGRATE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= INTEGRATE;
      cnt_q   <= 2'd0;
      acc_q   <= 2'd0;
      mode_q  <= 1'b0;
      run_q   <= 3'd0;
      rv_q    <= 1'b0;
      rec_q   <= 4'd0;
      fep_q   <= 1'b0;
      out_q   <= 1'b0;
      val_q   <= 1'b0;
      drp_q   <= 1'b0;
      err_q   <= 1'b0;
      sof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mode_q  <= mode_d;
      run_q   <= run_d;
      rv_q    <= rv_d;
      rec_q   <= rec_d;
      fep_q   <= fep_d;
      out_q   <= out_d;
      val_q   <= val_d;
      drp_q   <= drp_d;
      err_q   <= err_d;
      sof_q   <= sof_d;
    end
  end

  assign bitOut       = out_q;
  assign bitValid     = val_q;
  assign stuffDropped = drp_q;
  assign stuffError   = err_q;
  assign sofDetect    = sof_q;
  assign busIdle      = (state_q == IDLE);

endmodule

// File: tb/tb_can_bit_destuffer.sv
// Directed self-checking bench for can_bit_destuffer.
// Inputs change on falling edges; outputs are checked on falling edges.
module tb_can_bit_destuffer;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic sampleStrobe = 1'b0;
  logic sampleBit = 1'b0;
  logic multiSelect = 1'b0;
  logic bitRestart = 1'b0;
  logic stuffEnable = 1'b1;
  logic frameEnd = 1'b0;
  logic bitOut, bitValid, stuffDropped;
  logic stuffError, sofDetect, busIdle;

  int checks = 0;
  int errors = 0;

  can_bit_destuffer dut (
    .clk          (clk),
    .resetN       (resetN),
    .sampleStrobe (sampleStrobe),
    .sampleBit    (sampleBit),
    .multiSelect  (multiSelect),
    .bitRestart   (bitRestart),
    .stuffEnable  (stuffEnable),
    .frameEnd     (frameEnd),
    .bitOut       (bitOut),
    .bitValid     (bitValid),
    .stuffDropped (stuffDropped),
    .stuffError   (stuffError),
    .sofDetect    (sofDetect),
    .busIdle      (busIdle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got,
                     input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", tag, got, exp);
    end
  endtask

  task automatic expo(input string tag, input logic v,
                      input logic o, input logic s,
                      input logic d, input logic e);
    chk({tag, ".valid"}, bitValid, v);
    chk({tag, ".sof"}, sofDetect, s);
    chk({tag, ".drop"}, stuffDropped, d);
    chk({tag, ".err"}, stuffError, e);
    if (v) chk({tag, ".out"}, bitOut, o);
  endtask

  task automatic drive(input logic b, input logic fe,
                       input logic rs);
    @(negedge clk);
    sampleStrobe = 1'b1;
    sampleBit    = b;
    frameEnd     = fe;
    bitRestart   = rs;
    @(negedge clk);
    sampleStrobe = 1'b0;
    frameEnd     = 1'b0;
    bitRestart   = 1'b0;
  endtask

  task automatic ones(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      chk("integ.novalid", bitValid, 1'b0);
    end
  endtask

  initial begin
    logic [6:0] fr_b;
    logic [6:0] fr_v;
    logic [6:0] fr_d;
    logic [5:0] e_b;

    #3;
    chk("rst.valid", bitValid, 1'b0);
    chk("rst.out", bitOut, 1'b0);
    chk("rst.sof", sofDetect, 1'b0);
    chk("rst.drop", stuffDropped, 1'b0);
    chk("rst.err", stuffError, 1'b0);
    chk("rst.idle", busIdle, 1'b0);
    @(negedge clk);
    resetN = 1'b1;

    // 10 ones then a 0: no idle
    ones(10);
    chk("int10.idle", busIdle, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    chk("int0.idle", busIdle, 1'b0);
    chk("int0.valid", bitValid, 1'b0);
    ones(10);
    chk("int10b.idle", busIdle, 1'b0);
    ones(1);
    chk("int11.idle", busIdle, 1'b1);

    // SOF + five zeros, stuff 1, then 1
    fr_b = 7'b1100000;
    fr_v = 7'b1011111;
    fr_d = 7'b0100000;
    for (int i = 0; i < 7; i++) begin
      drive(fr_b[i], 1'b0, 1'b0);
      expo($sformatf("frame%0d", i), fr_v[i], fr_b[i],
           i == 0, fr_d[i], 1'b0);
    end
    // stuff bit counts as first of its run: 1 x5 then 0 dropped
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      expo($sformatf("run1_%0d", i), 1'b1, 1'b1, 1'b0,
           1'b0, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0);
    expo("stuff0", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    // six ones -> stuff error on the sixth
    e_b = 6'b011111;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      expo($sformatf("six%0d", i), e_b[i], 1'b1, 1'b0,
           1'b0, !e_b[i]);
    end
    chk("err.idle", busIdle, 1'b0);
    @(negedge clk);
    chk("err2.err", stuffError, 1'b0);
    chk("err2.idle", busIdle, 1'b0);
    // back in INTEGRATE: needs a full 11 ones
    ones(10);
    chk("reint10.idle", busIdle, 1'b0);
    ones(1);
    chk("reint11.idle", busIdle, 1'b1);

    // majority vote
    multiSelect = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    expo("mv.a1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    expo("mv.a2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    expo("mv.a3", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    expo("mv.b2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    expo("mv.b3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    // restart after two strobes discards them
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    bitRestart = 1'b1;
    @(negedge clk);
    bitRestart = 1'b0;
    chk("mv.rst.valid", bitValid, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    expo("mv.c1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    expo("mv.c3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // mode change mid-bit waits for the next bit
    drive(1'b1, 1'b0, 1'b0);
    multiSelect = 1'b0;
    drive(1'b1, 1'b0, 1'b0);
    expo("mv.d2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    expo("mv.d3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    expo("single", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // restart beats a coincident strobe
    drive(1'b1, 1'b0, 1'b1);
    chk("rs.strobe.valid", bitValid, 1'b0);

    // no destuffing: seven ones delivered
    stuffEnable = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      expo($sformatf("nse%0d", i), 1'b1, 1'b1, 1'b0,
           1'b0, 1'b0);
    end
    chk("nse.idle", busIdle, 1'b0);
    @(negedge clk);
    frameEnd = 1'b1;
    @(negedge clk);
    frameEnd = 1'b0;
    chk("fe.idle", busIdle, 1'b1);
    stuffEnable = 1'b1;
    // frameEnd in IDLE ignored
    @(negedge clk);
    frameEnd = 1'b1;
    @(negedge clk);
    frameEnd = 1'b0;
    chk("feidle.idle", busIdle, 1'b1);

    // frameEnd coincident with a bit
    drive(1'b0, 1'b0, 1'b0);
    expo("fc.sof", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    expo("fc.bit", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("fc.idle0", busIdle, 1'b0);
    @(negedge clk);
    chk("fc.idle1", busIdle, 1'b1);

    // async reset mid-RX
    drive(1'b0, 1'b0, 1'b0);
    expo("ar.sof", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    sampleStrobe = 1'b1;
    sampleBit    = 1'b1;
    @(posedge clk);
    #2;
    chk("ar.pre.valid", bitValid, 1'b1);
    resetN = 1'b0;
    #1;
    chk("ar.valid", bitValid, 1'b0);
    chk("ar.out", bitOut, 1'b0);
    chk("ar.sof0", sofDetect, 1'b0);
    chk("ar.idle", busIdle, 1'b0);
    sampleStrobe = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    expo("ar.nosof", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ones(10);
    chk("ar.int10", busIdle, 1'b0);
    ones(1);
    chk("ar.int11", busIdle, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    expo("ar.sof2", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
